// File: rtl/wb_control.sv
// Writeback register-file write-port controller: MW-stage decode plus one outstanding mul/div result.
// Optional feature: define WB_RSTATUS_EN to redirect overflow/exception results to rstatus (r30).
module wb_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mw_ir,
  input  logic [31:0] mw_o,
  input  logic [31:0] mw_d,
  input  logic [31:0] mw_pc1,
  input  logic        mw_ovf,
  input  logic        md_issue,
  input  logic [31:0] md_ir,
  input  logic        md_rdy,
  input  logic [31:0] md_result,
  input  logic        md_exc,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        md_busy,
  output logic        md_pend_valid,
  output logic [4:0]  md_pend_rd,
  output logic        mw_stall
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;
`ifdef WB_RSTATUS_EN
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     md_rd_q, md_rd_d;
  logic              md_div_q, md_div_d;
  logic [XLEN-1:0]   md_res_q, md_res_d;
  logic              md_exc_q, md_exc_d;

  logic [4:0]        mw_opcode, mw_alu;
  logic              mw_we;
  logic [RW-1:0]     mw_reg;
  logic [XLEN-1:0]   mw_data;
  logic              mw_act;

  logic              md_src_exc;
  logic [RW-1:0]     md_reg;
  logic [XLEN-1:0]   md_data;

  assign mw_opcode = mw_ir[31:27];
  assign mw_alu    = mw_ir[6:2];

  // MW-stage write decode
  always_comb begin
    mw_we   = 1'b0;
    mw_reg  = mw_ir[26:22];
    mw_data = mw_o;
    case (mw_opcode)
      OP_RTYPE: begin
        mw_we = (mw_alu[4:1] != 4'b0011);
`ifdef WB_RSTATUS_EN
        if (mw_ovf && mw_alu == ALU_ADD) begin
          mw_reg  = REG_STATUS;
          mw_data = 32'd1;
        end else if (mw_ovf && mw_alu == ALU_SUB) begin
          mw_reg  = REG_STATUS;
          mw_data = 32'd3;
        end
`endif
      end
      OP_ADDI: begin
        mw_we = 1'b1;
`ifdef WB_RSTATUS_EN
        if (mw_ovf) begin
          mw_reg  = REG_STATUS;
          mw_data = 32'd2;
        end
`endif
      end
      OP_LW: begin
        mw_we   = 1'b1;
        mw_data = mw_d;
      end
      OP_JAL: begin
        mw_we   = 1'b1;
        mw_reg  = REG_LINK;
        mw_data = mw_pc1;
      end
      OP_SETX: begin
        mw_we   = 1'b1;
        mw_reg  = REG_STATUS;
        mw_data = {5'b0, mw_ir[26:0]};
      end
      default: mw_we = 1'b0;
    endcase
  end

  assign mw_act = mw_we && (mw_reg != '0);

  // Multdiv write source: live result in BUSY, buffered copy in HOLD
  always_comb begin
    md_src_exc = (state_q == S_HOLD) ? md_exc_q : md_exc;
    md_reg     = md_rd_q;
    md_data    = (state_q == S_HOLD) ? md_res_q : md_result;
`ifdef WB_RSTATUS_EN
    if (md_src_exc) begin
      md_reg  = REG_STATUS;
      md_data = md_div_q ? 32'd5 : 32'd4;
    end
`endif
  end

  // Write-port arbitration
  always_comb begin
    ctrl_writeEnable = mw_act;
    ctrl_writeReg    = mw_reg;
    data_writeReg    = mw_data;
    case (state_q)
      S_HOLD: begin
        ctrl_writeEnable = (md_reg != '0);
        ctrl_writeReg    = md_reg;
        data_writeReg    = md_data;
      end
      S_BUSY: begin
        if (md_rdy && !mw_act) begin
          ctrl_writeEnable = (md_reg != '0);
          ctrl_writeReg    = md_reg;
          data_writeReg    = md_data;
        end
      end
      default: ;
    endcase
    if (reset) ctrl_writeEnable = 1'b0;
  end

  // Next-state and buffer capture
  always_comb begin
    state_d  = state_q;
    md_rd_d  = md_rd_q;
    md_div_d = md_div_q;
    md_res_d = md_res_q;
    md_exc_d = md_exc_q;
    case (state_q)
      S_IDLE: begin
        if (md_issue) begin
          md_rd_d  = md_ir[26:22];
          md_div_d = md_ir[2];
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (md_rdy) begin
          md_res_d = md_result;
          md_exc_d = md_exc;
          state_d  = mw_act ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      md_rd_q  <= '0;
      md_div_q <= 1'b0;
      md_res_q <= '0;
      md_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_rd_q  <= md_rd_d;
      md_div_q <= md_div_d;
      md_res_q <= md_res_d;
      md_exc_q <= md_exc_d;
    end
  end

  assign md_busy       = (state_q != S_IDLE);
  assign md_pend_valid = md_busy;
  assign md_pend_rd    = md_rd_q;
  assign mw_stall      = (state_q == S_HOLD);

  // Issue-word fields other than rd and the mul/div select bit are don't-care here
  logic unused_md_ir;
  assign unused_md_ir = ^{md_ir[31:27], md_ir[21:3], md_ir[1:0]};
`ifndef WB_RSTATUS_EN
  logic unused_cfg;
  assign unused_cfg = ^{mw_ovf, md_src_exc, md_div_q};
`endif

endmodule

// File: tb/tb_wb_control.sv
// Bench for wb_control: directed test-plan cases plus randomized traffic against a queue-based reference model.
module tb_wb_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mw_ir, mw_o, mw_d, mw_pc1;
  logic        mw_ovf, md_issue, md_rdy, md_exc;
  logic [31:0] md_ir, md_result;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        md_busy, md_pend_valid, mw_stall;
  logic [4:0]  md_pend_rd;

  int n_checks = 0;
  int n_errors = 0;

  wb_control dut (
    .clock(clock), .reset(reset),
    .mw_ir(mw_ir), .mw_o(mw_o), .mw_d(mw_d), .mw_pc1(mw_pc1), .mw_ovf(mw_ovf),
    .md_issue(md_issue), .md_ir(md_ir), .md_rdy(md_rdy), .md_result(md_result), .md_exc(md_exc),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .md_busy(md_busy), .md_pend_valid(md_pend_valid), .md_pend_rd(md_pend_rd), .mw_stall(mw_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          we;
    logic [4:0]  rg;
    logic [31:0] dat;
  } wr_t;

  // Reference model: one outstanding op plus a queue of results waiting for the port
  bit         m_pend = 1'b0;
  logic [4:0] m_rd   = 5'd0;
  bit         m_div  = 1'b0;
  wr_t        m_defer[$];

  function automatic logic [31:0] rtype(input logic [4:0] alu, input logic [4:0] rd);
    return {5'b0, rd, 15'b0, alu, 2'b0};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [21:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic wr_t mw_model();
    wr_t w;
    logic [4:0] op, alu;
    op = mw_ir[31:27];
    alu = mw_ir[6:2];
    w.we = 1'b0; w.rg = mw_ir[26:22]; w.dat = mw_o;
    if (op == 5'b00000) begin
      w.we = !(alu == 5'b00110 || alu == 5'b00111);
`ifdef WB_RSTATUS_EN
      if (mw_ovf && alu == 5'b00000) begin w.rg = 5'd30; w.dat = 32'd1; end
      if (mw_ovf && alu == 5'b00001) begin w.rg = 5'd30; w.dat = 32'd3; end
`endif
    end else if (op == 5'b00101) begin
      w.we = 1'b1;
`ifdef WB_RSTATUS_EN
      if (mw_ovf) begin w.rg = 5'd30; w.dat = 32'd2; end
`endif
    end else if (op == 5'b01000) begin
      w.we = 1'b1; w.dat = mw_d;
    end else if (op == 5'b00011) begin
      w.we = 1'b1; w.rg = 5'd31; w.dat = mw_pc1;
    end else if (op == 5'b10101) begin
      w.we = 1'b1; w.rg = 5'd30; w.dat = mw_ir & 32'h07FF_FFFF;
    end
    if (w.rg == 5'd0) w.we = 1'b0;
    return w;
  endfunction

  function automatic wr_t md_model(input logic [31:0] res, input bit exc);
    wr_t w;
    w.rg = m_rd; w.dat = res;
`ifdef WB_RSTATUS_EN
    if (exc) begin w.rg = 5'd30; w.dat = m_div ? 32'd5 : 32'd4; end
`else
    if (exc) w.dat = res;
`endif
    w.we = (w.rg != 5'd0);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Compare all outputs against the model for the current cycle
  task automatic settle();
    wr_t mw, e;
    bit  stall, busy;
    #2;
    mw = mw_model();
    e = mw;
    stall = 1'b0;
    if (m_defer.size() > 0) begin
      e = m_defer[0];
      stall = 1'b1;
    end else if (m_pend && md_rdy && !mw.we) begin
      e = md_model(md_result, md_exc);
    end
    if (reset) e.we = 1'b0;
    busy = m_pend || (m_defer.size() > 0);
    chk("we", 32'(ctrl_writeEnable), 32'(e.we));
    if (e.we) begin
      chk("reg", 32'(ctrl_writeReg), 32'(e.rg));
      chk("data", data_writeReg, e.dat);
    end
    chk("stall", 32'(mw_stall), 32'(stall));
    chk("busy", 32'(md_busy), 32'(busy));
    chk("pend_valid", 32'(md_pend_valid), 32'(busy));
    if (busy) chk("pend_rd", 32'(md_pend_rd), 32'(m_rd));
  endtask

  // Advance the model across the rising edge
  task automatic advance();
    wr_t mw;
    @(posedge clock);
    mw = mw_model();
    if (reset) begin
      m_pend = 1'b0;
      m_defer.delete();
    end else if (m_defer.size() > 0) begin
      void'(m_defer.pop_front());
    end else if (m_pend) begin
      if (md_rdy) begin
        if (mw.we) m_defer.push_back(md_model(md_result, md_exc));
        m_pend = 1'b0;
      end
    end else if (md_issue) begin
      m_pend = 1'b1;
      m_rd = md_ir[26:22];
      m_div = (md_ir[6:2] == 5'b00111);
    end
    @(negedge clock);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic clr();
    reset = 1'b0; mw_ir = '0; mw_o = '0; mw_d = '0; mw_pc1 = '0; mw_ovf = 1'b0;
    md_issue = 1'b0; md_ir = '0; md_rdy = 1'b0; md_result = '0; md_exc = 1'b0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    m_pend = 1'b0;
    settle();
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_pend_rd", 32'(md_pend_rd), 32'd0);
    chk("rst_stall", 32'(mw_stall), 32'd0);
    advance();
    reset = 1'b0;

    // add r3
    mw_ir = rtype(5'b00000, 5'd3); mw_o = 32'd7;
    settle();
    chk("add_we", 32'(ctrl_writeEnable), 32'd1);
    chk("add_reg", 32'(ctrl_writeReg), 32'd3);
    chk("add_data", data_writeReg, 32'd7);
    advance();
    mw_ovf = 1'b1;
    settle();
`ifdef WB_RSTATUS_EN
    chk("add_ovf_reg", 32'(ctrl_writeReg), 32'd30);
    chk("add_ovf_data", data_writeReg, 32'd1);
`else
    chk("add_ovf_reg", 32'(ctrl_writeReg), 32'd3);
    chk("add_ovf_data", data_writeReg, 32'd7);
`endif
    advance();
    mw_ovf = 1'b0;

    // lw, jal, addi r0
    mw_ir = itype(5'b01000, 5'd5, 22'd0); mw_d = 32'hDEAD;
    settle();
    chk("lw_reg", 32'(ctrl_writeReg), 32'd5);
    chk("lw_data", data_writeReg, 32'hDEAD);
    advance();
    mw_ir = itype(5'b00011, 5'd0, 22'h40); mw_pc1 = 32'h40;
    settle();
    chk("jal_reg", 32'(ctrl_writeReg), 32'd31);
    chk("jal_data", data_writeReg, 32'h40);
    advance();
    mw_ir = itype(5'b00101, 5'd0, 22'd9);
    settle();
    chk("addi_r0_we", 32'(ctrl_writeEnable), 32'd0);
    advance();
    mw_ir = '0;

    // mul r4, result 10 cycles later with the port free
    md_issue = 1'b1; md_ir = rtype(5'b00110, 5'd4);
    tick();
    md_issue = 1'b0;
    for (int i = 1; i < 10; i++) begin
      settle();
      chk("mul_busy", 32'(md_busy), 32'd1);
      chk("mul_pend_rd", 32'(md_pend_rd), 32'd4);
      advance();
    end
    md_rdy = 1'b1; md_result = 32'd42;
    settle();
    chk("mul_we", 32'(ctrl_writeEnable), 32'd1);
    chk("mul_reg", 32'(ctrl_writeReg), 32'd4);
    chk("mul_data", data_writeReg, 32'd42);
    advance();
    md_rdy = 1'b0;
    settle();
    chk("mul_done_busy", 32'(md_busy), 32'd0);
    advance();

    // div r6 collides with lw r2
    md_issue = 1'b1; md_ir = rtype(5'b00111, 5'd6);
    tick();
    md_issue = 1'b0;
    tick();
    md_rdy = 1'b1; md_result = 32'h99;
    mw_ir = itype(5'b01000, 5'd2, 22'd0); mw_d = 32'h11;
    settle();
    chk("col_lw_reg", 32'(ctrl_writeReg), 32'd2);
    chk("col_lw_data", data_writeReg, 32'h11);
    advance();
    md_rdy = 1'b0;
    settle();
    chk("col_hold_stall", 32'(mw_stall), 32'd1);
    chk("col_hold_reg", 32'(ctrl_writeReg), 32'd6);
    chk("col_hold_data", data_writeReg, 32'h99);
    advance();
    settle();
    chk("col_idle_stall", 32'(mw_stall), 32'd0);
    chk("col_idle_busy", 32'(md_busy), 32'd0);
    advance();
    mw_ir = '0;

    // div r7 with exception; a second issue while busy is ignored
    md_issue = 1'b1; md_ir = rtype(5'b00111, 5'd7);
    tick();
    md_ir = rtype(5'b00110, 5'd9);
    settle();
    chk("dup_pend_rd", 32'(md_pend_rd), 32'd7);
    advance();
    md_issue = 1'b0; md_rdy = 1'b1; md_exc = 1'b1; md_result = 32'h1234;
    settle();
`ifdef WB_RSTATUS_EN
    chk("exc_reg", 32'(ctrl_writeReg), 32'd30);
    chk("exc_data", data_writeReg, 32'd5);
`else
    chk("exc_reg", 32'(ctrl_writeReg), 32'd7);
    chk("exc_data", data_writeReg, 32'h1234);
`endif
    advance();
    md_rdy = 1'b0; md_exc = 1'b0;

    // reset while busy discards the result
    md_issue = 1'b1; md_ir = rtype(5'b00110, 5'd8);
    tick();
    md_issue = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; md_rdy = 1'b1; md_result = 32'd5;
    settle();
    chk("rst_busy_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_busy_busy", 32'(md_busy), 32'd0);
    advance();
    md_rdy = 1'b0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int k;
      logic [4:0] rd, alu;
      reset = ($urandom_range(0, 199) == 0);
      rd = 5'($urandom_range(0, 31));
      k = $urandom_range(0, 6);
      case (k)
        0: begin
          alu = 5'($urandom_range(0, 7));
          mw_ir = rtype(alu, rd);
        end
        1: mw_ir = itype(5'b00101, rd, 22'($urandom));
        2: mw_ir = itype(5'b01000, rd, 22'($urandom));
        3: mw_ir = itype(5'b00011, rd, 22'($urandom));
        4: mw_ir = itype(5'b10101, rd, 22'($urandom));
        5: mw_ir = $urandom;
        default: mw_ir = '0;
      endcase
      mw_o = $urandom; mw_d = $urandom; mw_pc1 = $urandom;
      mw_ovf = ($urandom_range(0, 3) == 0);
      md_issue = ($urandom_range(0, 3) == 0);
      md_ir = rtype(($urandom_range(0, 1) == 1) ? 5'b00111 : 5'b00110, 5'($urandom_range(0, 31)));
      md_rdy = ($urandom_range(0, 4) == 0);
      md_result = $urandom;
      md_exc = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
